// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// Optional feature macro: MIPS_CTRL_ADDI_EN (adds the ADDIEX/ADDIWB path).
package mips_ctrl_pkg;

    // FSM states, 4-bit encoding
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation request handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control word produced per state. mem_gated marks states whose
    // enables are only valid while memory reports ready.
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       instr_done;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       mem_gated;
    } ctrl_t;

    // True for every opcode this controller executes
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_CTRL_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder for mips_multicycle_control.
// Optional feature macro: MIPS_CTRL_ADDI_EN (decodes ADDIEX/ADDIWB).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Moore decode: every field not set for a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.mem_gated = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord      = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                ctrl.mem_gated  = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and
// mem_ready / rst_n gating of the write enables around mips_ctrl_outdec.
// Optional feature macro: MIPS_CTRL_ADDI_EN (addi via ADDIEX -> ADDIWB).
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       branch,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t state;
    state_t state_nxt;
    ctrl_t  cw;

    // State register; async reset returns to FETCH so selects show FETCH values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state logic: opcode dispatch in DECODE, memory stalls in FETCH/MEMRD/MEMWR
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_nxt = S_ADDIEX;
`endif
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
            S_EXECUTE: state_nxt = S_ALUWB;
            S_ALUWB:   state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_JUMP:    state_nxt = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX:  state_nxt = S_ADDIWB;
            S_ADDIWB:  state_nxt = S_FETCH;
`endif
            default:   state_nxt = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (cw)
    );

    // Output gating: enables need rst_n high and, in memory-phase states, mem_ready
    always_comb begin
        logic en_ok;
        en_ok      = rst_n & (mem_ready | ~cw.mem_gated);
        pc_write   = cw.pc_write   & en_ok;
        ir_write   = cw.ir_write   & en_ok;
        reg_write  = cw.reg_write  & en_ok;
        mem_write  = cw.mem_write  & en_ok;
        branch     = cw.branch     & en_ok;
        instr_done = cw.instr_done & en_ok;
        illegal_op = rst_n & (state == S_DECODE) & ~op_supported(op);
        iord       = cw.iord;
        reg_dst    = cw.reg_dst;
        mem_to_reg = cw.mem_to_reg;
        alu_src_a  = cw.alu_src_a;
        alu_src_b  = cw.alu_src_b;
        pc_src     = cw.pc_src;
        alu_op     = cw.alu_op;
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control.
// Honours MIPS_CTRL_ADDI_EN to pick the expected addi behaviour.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_write, branch;
    logic       iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       illegal_op, instr_done;

    int total = 0;
    int bad   = 0;

    mips_multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .branch     (branch),
        .iord       (iord),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Expected per-instruction summary
    typedef struct {
        int          len;
        int          pcw;
        int          rw;
        int          mw;
        int          br;
        int          ill;
        int          done;
        int          funct;
        logic [11:0] endv;
        bit          mem;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: latency table plus stall cycles, and the
    // number of times each enable must fire over the whole instruction.
    function automatic exp_t model(input logic [5:0] opc, input int fs, input int ms);
        exp_t e;
        e.pcw = 1; e.rw = 0; e.mw = 0; e.br = 0; e.ill = 0; e.done = 1;
        e.funct = 0; e.mem = 0;
        // endv = {iord, alu_src_a, alu_src_b, mem_to_reg, reg_dst, branch, pc_write, pc_src, alu_op}
        if (opc == 6'b100011) begin
            e.len = 5; e.rw = 1; e.mem = 1; e.endv = 12'h080;
        end else if (opc == 6'b101011) begin
            e.len = 4; e.mw = 1; e.mem = 1; e.endv = 12'h800;
        end else if (opc == 6'b000000) begin
            e.len = 4; e.rw = 1; e.funct = 1; e.endv = 12'h040;
        end else if (opc == 6'b000100) begin
            e.len = 3; e.br = 1; e.endv = 12'h425;
        end else if (opc == 6'b000010) begin
            e.len = 3; e.pcw = 2; e.endv = 12'h018;
`ifdef MIPS_CTRL_ADDI_EN
        end else if (opc == 6'b001000) begin
            e.len = 4; e.rw = 1; e.endv = 12'h000;
`endif
        end else begin
            e.len = 2; e.ill = 1; e.done = 0; e.endv = 12'h300;
        end
        e.len = e.len + fs + (e.mem ? ms : 0);
        return e;
    endfunction

    // Run one instruction: fs not-ready cycles in FETCH, ms in the memory phase.
    // mem_ready is random wherever it must not matter; op is junk during FETCH.
    task automatic run_instr(input logic [5:0] opc, input int fs, input int ms);
        exp_t e;
        int c = 0;
        bit ended = 0;
        int n_ir = 0, n_pcw = 0, n_rw = 0, n_mw = 0, n_br = 0;
        int n_ill = 0, n_done = 0, n_funct = 0;
        logic [11:0] endv = '0;
        string t;
        e = model(opc, fs, ms);
        t = $sformatf("op%02h_fs%0d_ms%0d", opc, fs, ms);
        while (!ended && c < 60) begin
            @(negedge clk);
            if (c < fs) begin
                mem_ready = 1'b0; op = 6'($urandom);
            end else if (c == fs) begin
                mem_ready = 1'b1; op = 6'($urandom);
            end else begin
                op = opc;
                if (e.mem && c >= fs + 3) mem_ready = (c >= fs + 3 + ms);
                else                      mem_ready = 1'($urandom);
            end
            #1;
            c++;
            n_ir    += int'(ir_write);
            n_pcw   += int'(pc_write);
            n_rw    += int'(reg_write);
            n_mw    += int'(mem_write);
            n_br    += int'(branch);
            n_ill   += int'(illegal_op);
            n_done  += int'(instr_done);
            n_funct += int'(alu_op == 2'b10);
            if (instr_done || illegal_op) begin
                ended = 1;
                endv = {iord, alu_src_a, alu_src_b, mem_to_reg, reg_dst, branch,
                        pc_write, pc_src, alu_op};
            end
        end
        chk({t, "_len"},   c,       e.len);
        chk({t, "_ir"},    n_ir,    1);
        chk({t, "_pcw"},   n_pcw,   e.pcw);
        chk({t, "_rw"},    n_rw,    e.rw);
        chk({t, "_mw"},    n_mw,    e.mw);
        chk({t, "_br"},    n_br,    e.br);
        chk({t, "_ill"},   n_ill,   e.ill);
        chk({t, "_done"},  n_done,  e.done);
        chk({t, "_funct"}, n_funct, e.funct);
        chk({t, "_last"},  endv,    e.endv);
    endtask

    function automatic logic [6:0] enables();
        return {pc_write, ir_write, reg_write, mem_write, branch, illegal_op, instr_done};
    endfunction

    initial begin
        logic [5:0] r;
        rst_n = 1'b0; op = 6'b000000; mem_ready = 1'b1;

        // reset state: enables forced low even with mem_ready high in FETCH
        @(negedge clk); #1;
        chk("rst_enables", enables(), 7'd0);
        chk("rst_srcb",    alu_src_b, 2'b01);
        chk("rst_sel",     {iord, reg_dst, mem_to_reg, alu_src_a, pc_src, alu_op}, 10'd0);
        mem_ready = 1'b0;
        rst_n = 1'b1;

        // directed instructions
        run_instr(6'b100011, 0, 0);   // lw, 5 cycles
        run_instr(6'b000000, 0, 0);   // R-type, 4 cycles
        run_instr(6'b101011, 3, 2);   // sw with stalls, 9 cycles
        run_instr(6'b000100, 0, 0);   // beq
        run_instr(6'b000010, 0, 0);   // j
        run_instr(6'b111111, 0, 0);   // illegal
        run_instr(6'b001000, 0, 0);   // addi (legal only with the macro)
        run_instr(6'b100011, 2, 3);   // lw with stalls

        // reset asserted mid-lw while stalled in MEMRD
        @(negedge clk); op = 6'b100011; mem_ready = 1'b1;     // FETCH
        @(negedge clk); mem_ready = 1'($urandom);              // DECODE
        @(negedge clk); mem_ready = 1'($urandom);              // MEMADR
        @(negedge clk); mem_ready = 1'b0; #1;                  // MEMRD
        chk("memrd_iord", iord, 1'b1);
        rst_n = 1'b0; mem_ready = 1'b1; #1;
        chk("midrst_enables", enables(), 7'd0);
        chk("midrst_sel", {iord, alu_src_a, alu_src_b, pc_src, alu_op}, 8'b0_0_01_00_00);
        @(negedge clk); #1;
        chk("midrst_hold_enables", enables(), 7'd0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        run_instr(6'b100011, 1, 0);

        // randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: r = 6'b100011;
                1: r = 6'b101011;
                2: r = 6'b000000;
                3: r = 6'b000100;
                4: r = 6'b000010;
                5: r = 6'b001000;
                default: r = 6'($urandom);
            endcase
            run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle main control FSM for the MIPS datapath, and the producer of the `alu_op` code that the ALU control decoder consumes alongside `funct`. It decodes the 6-bit opcode over several cycles and drives all datapath selects and write enables, stalling on a memory ready handshake. Supports lw, sw, R-type, beq and j, with addi as a compile-time option.

## Interface
- No parameters; encodings are fixed in the shared package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op` in 6: opcode, i.e. IR[31:26]. Sampled in DECODE and MEMADR.
- `mem_ready` in 1: memory access completes in this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_write` out 1 each: write enables.
- `branch` out 1: PC write qualified by ALU zero.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `reg_dst`, `mem_to_reg`, `alu_src_a` out 1 each: datapath selects.
- `alu_src_b` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `instr_done` out 1: high in the last cycle of each instruction.

## Operation
- Moore FSM: all outputs are decoded from the state only, except that the memory-phase enables are ANDed with `mem_ready`.
- Any output not listed for a state is 0.
- States, their outputs, and the next state:
  - FETCH: `alu_src_b`=01, `alu_op`=00, `pc_src`=00, `ir_write`=`pc_write`=`mem_ready`. Next: DECODE if `mem_ready`, else stay in FETCH.
  - DECODE: `alu_src_b`=11, `alu_op`=00. Next by `op`:
    - lw (100011) or sw (101011): MEMADR.
    - R-type (000000): EXECUTE.
    - beq (000100): BRANCH.
    - j (000010): JUMP.
    - addi (001000): ADDIEX.
    - Any other opcode: `illegal_op`=1, next FETCH.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: MEMRD for lw, otherwise MEMWR.
  - MEMRD: `iord`=1. Next: MEMWB if `mem_ready`, else stay.
  - MEMWB: `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. Next: FETCH.
  - MEMWR: `iord`=1, `mem_write`=`mem_ready`, `instr_done`=`mem_ready`. Next: FETCH if `mem_ready`, else stay.
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: ALUWB.
  - ALUWB: `reg_dst`=1, `reg_write`=1, `instr_done`=1. Next: FETCH.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1, `instr_done`=1. Next: FETCH.
  - ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: ADDIWB.
  - ADDIWB: `reg_write`=1, `instr_done`=1. Next: FETCH.
  - JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1. Next: FETCH.
- Illegal opcode: no register, memory or PC write occurs. The PC has already advanced by 4 in FETCH.

## Timing
- Latency with `mem_ready` held high: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds exactly one cycle. During those cycles all enables stay 0.
- Reset value: state = FETCH.
  - While `rst_n` is 0, every write enable, `branch`, `illegal_op` and `instr_done` is forced to 0 combinationally.
  - Selects hold their FETCH values during reset: `alu_src_b`=01, all others 0.
- Reset asserted mid-instruction: the state goes to FETCH immediately and the write enables drop in the same cycle. The first fetch happens after release, on the first edge with `mem_ready`=1.
- `op` only needs to be stable in DECODE and MEMADR, because IR is written only in FETCH.

## Configuration
- `MIPS_CTRL_ADDI_EN` defined: addi follows DECODE → ADDIEX → ADDIWB.
- `MIPS_CTRL_ADDI_EN` undefined: the ADDIEX and ADDIWB states are not compiled in. Opcode 001000 takes the illegal path (`illegal_op` pulse, back to FETCH, no writes).

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit encoding);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - `alu_op` constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - `alu_src_b` and `pc_src` select constants.
- Sub-module `mips_ctrl_outdec`: purely combinational state-to-control-word decoder. The top-level keeps the state register, the next-state logic and the `mem_ready`/`rst_n` gating.

## Test plan
- Reset, then lw (`op`=100011) with `mem_ready`=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5, with `instr_done`=1 in that cycle.
- R-type (`op`=000000): `alu_op`=10 only in the EXECUTE cycle. `reg_dst`=1 and `reg_write`=1 in the ALUWB cycle. 4 cycles in total.
- sw with `mem_ready` held low for 3 cycles in FETCH and 2 cycles in MEMWR:
  - `ir_write` and `mem_write` each pulse exactly once;
  - total 9 cycles.
- beq gives `alu_op`=01, `pc_src`=01, `branch`=1 in cycle 3. j gives `pc_src`=10, `pc_write`=1 in cycle 3.
- `op`=111111 gives an `illegal_op` pulse in DECODE, then FETCH, with no write enables. Build without `MIPS_CTRL_ADDI_EN` and drive `op`=001000: same result. With the macro, addi takes 4 cycles and asserts `reg_write` in cycle 4.
- `rst_n` driven low during MEMRD: all enables are 0 in the same cycle and the state is FETCH. After release, the next lw completes normally.
